map_blitter: RTL
================

MAP_BLITTER -- requirements
Module: map_blitter

Interface
REQ-001 clock  in  1  single system/CPU clock; every register is updated on its rising edge.
REQ-002 reset_n  in  1  reset, synchronous and active-low.
REQ-003 blit_cs  in  1  CPU chip select for the blitter register block.
REQ-004 read, write  in  1 each  CPU bus strobes, qualified by blit_cs.
REQ-005 address  in  [4:2]  register select: 0 SRC, 1 DST, 2 SIZE, 3 FILL, 4 CTRL/STATUS.
REQ-006 data_in  in  32  CPU write data.
REQ-007 data_out  out  32  CPU read data, registered (1-cycle latency).
REQ-008 cpu_map_busy  in  1  high when the CPU drives the map RAM CPU-side port this cycle.
REQ-009 map_cs, map_read, map_write  out  1 each  blitter strobes into the map RAM CPU-side port.
REQ-010 map_address  out  [11:2]  tile address: [11:7] row, [6:2] column.
REQ-011 map_wdata  out  8  tile index to write.
REQ-012 map_rdata  in  8  tile index read; valid the cycle after map_read.
REQ-013 done  out  1  one-cycle pulse when an operation completes normally.

Function
REQ-014 SRC and DST hold bits [11:2] (row, column); SIZE holds width-1 in [4:0] and height-1 in [12:8]; FILL holds a tile index in [7:0].
REQ-015 CTRL write: bit0 start, bit1 mode (0 fill, 1 copy), bit2 abort. STATUS read: bit0 busy, bit1 mode.
REQ-016 Writes to SRC, DST, SIZE or FILL while busy shall be ignored.
REQ-017 A start while busy shall be ignored.
REQ-018 States: IDLE, RD, LATCH, WR.
REQ-019 Start in IDLE shall set busy and load the row/column counters to 0. Fill mode goes to WR; copy mode goes to RD.
REQ-020 RD: map_cs=map_read=1, map_address=SRC+offset, then LATCH. If cpu_map_busy, strobes stay 0 and the state is held.
REQ-021 LATCH: capture map_rdata into a hold register, then WR. This state is never stalled.
REQ-022 WR: map_cs=map_write=1, map_address=DST+offset, map_wdata=FILL (fill) or hold (copy). If cpu_map_busy, strobes stay 0 and the state is held.
REQ-023 After each non-stalled WR, the column advances. At width-1 the column resets to 0 and the row advances. At the final row and column the block returns to IDLE: busy clears and done pulses for one cycle.
REQ-024 Offset addition is per field, modulo 32; row and column each wrap independently with no carry between them.
REQ-025 Traversal order is row-major, ascending. An overlapping copy gives exactly the result of this order; there is no memmove semantics.
REQ-026 Throughput: fill 1 tile/cycle; copy 3 cycles/tile; each stalled cycle adds 1.
REQ-027 Abort in any state: IDLE on the next edge, busy=0, no done pulse, no further map strobes. Tiles already written stay written.
REQ-028 Start and abort in the same CTRL write: abort wins and no operation starts.
REQ-029 Map strobes shall never be asserted while cpu_map_busy=1.

Reset
REQ-030 reset_n=0 shall force IDLE and clear SRC, DST, SIZE, FILL, the counters, hold, data_out, done, busy and all map strobes, all to 0. This applies mid-operation with no further writes.

Structure
REQ-031 A shared package holds the register offsets, CTRL bit positions, state encoding and field widths (row 5, column 5, tile 8).
REQ-032 One natural sub-module: map_blit_addr_gen, holding the row/column counters, wrap-add and last-tile detection.

Verification
REQ-033 Fill DST=0x000 (row 0, col 0), SIZE w=4 h=2, FILL=0x11 -> 8 writes at rows 0-1, cols 0-3; done at cycle 9 after start.
REQ-034 Copy SRC=(2,30), DST=(5,0), w=4 h=1 -> reads of cols 30,31,0,1 on row 2; writes to (5,0..3) with the matching data; done after 12 cycles.
REQ-035 Fill w=8 with cpu_map_busy high for 3 cycles mid-run -> no strobe while busy; completion delayed exactly 3 cycles; all 8 tiles written once.
REQ-036 Abort after 5 of 16 fill writes -> busy=0 on the next cycle; no done pulse; exactly 5 writes seen.
REQ-037 Start while busy, plus a SIZE write while busy -> no effect on the running operation or SIZE; STATUS reads busy=1.
REQ-038 reset_n low for 1 cycle mid-copy -> all outputs 0 the next cycle; STATUS reads 0.

Source files
------------

// File: rtl/map_blitter_pkg.sv
// map_blitter_pkg
// Shared definitions for the tile-map blitter: CPU register offsets, CTRL and
// STATUS bit positions, field widths, the FSM state encoding and the per-field
// wrap-around address helper.
package map_blitter_pkg;

    localparam int ROW_W  = 5;
    localparam int COL_W  = 5;
    localparam int TILE_W = 8;
    localparam int ADDR_W = ROW_W + COL_W;

    // Register select values on address[4:2]
    localparam logic [2:0] REG_SRC  = 3'd0;
    localparam logic [2:0] REG_DST  = 3'd1;
    localparam logic [2:0] REG_SIZE = 3'd2;
    localparam logic [2:0] REG_FILL = 3'd3;
    localparam logic [2:0] REG_CTRL = 3'd4;

    // CTRL write bits
    localparam int CTRL_START = 0;
    localparam int CTRL_MODE  = 1;
    localparam int CTRL_ABORT = 2;

    // STATUS read bits
    localparam int STAT_BUSY = 0;
    localparam int STAT_MODE = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        LATCH = 2'd2,
        WR    = 2'd3
    } state_t;

    // Row in the upper field, column in the lower, matching map_address[11:7]/[6:2]
    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } tile_pos_t;

    // Row and column wrap independently modulo 32; no carry crosses fields.
    function automatic tile_pos_t wrap_add(input tile_pos_t base,
                                           input logic [ROW_W-1:0] row_off,
                                           input logic [COL_W-1:0] col_off);
        tile_pos_t r;
        r.row = base.row + row_off;
        r.col = base.col + col_off;
        return r;
    endfunction

endpackage

// File: rtl/map_blitter_if.sv
// map_blitter_if
// Bundles the CPU register bus and the blitter's side of the map RAM CPU port.
//   CPU bus : blit_cs, read, write, address[4:2], data_in -> data_out (registered)
//   Map RAM : map_cs/map_read/map_write, map_address[11:2], map_wdata -> map_rdata
//   Other   : cpu_map_busy (stall input), done (completion pulse)
// Handshake: there is no ready/valid pair. Every map strobe is a one-cycle
// command accepted unconditionally by the RAM; map_rdata is valid the cycle
// after map_read. cpu_map_busy=1 means the CPU owns the RAM port this cycle,
// so the blitter drops its strobes and holds its state until it clears.
// slave modport = blitter, master modport = host/RAM side.
interface map_blitter_if;
    import map_blitter_pkg::*;

    logic              blit_cs;
    logic              read;
    logic              write;
    logic [4:2]        address;
    logic [31:0]       data_in;
    logic [31:0]       data_out;
    logic              cpu_map_busy;
    logic              map_cs;
    logic              map_read;
    logic              map_write;
    logic [11:2]       map_address;
    logic [TILE_W-1:0] map_wdata;
    logic [TILE_W-1:0] map_rdata;
    logic              done;

    modport slave (
        input  blit_cs, read, write, address, data_in, cpu_map_busy, map_rdata,
        output data_out, map_cs, map_read, map_write, map_address, map_wdata, done
    );

    modport master (
        output blit_cs, read, write, address, data_in, cpu_map_busy, map_rdata,
        input  data_out, map_cs, map_read, map_write, map_address, map_wdata, done
    );

endinterface

// File: rtl/map_blit_addr_gen.sv
// map_blit_addr_gen
// Row/column traversal counters for the blitter plus source/destination
// address generation.
//   clock, reset_n      : clock, synchronous active-low reset
//   load                : clear row/column to 0 at operation start
//   advance             : step one tile in row-major order
//   width_m1, height_m1 : block size minus one
//   src, dst            : block origins
//   src_addr, dst_addr  : origin + offset, each field wrapping modulo 32
//   last                : current offset is the final tile of the block
module map_blit_addr_gen
    import map_blitter_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic             advance,
    input  logic [COL_W-1:0] width_m1,
    input  logic [ROW_W-1:0] height_m1,
    input  tile_pos_t        src,
    input  tile_pos_t        dst,
    output tile_pos_t        src_addr,
    output tile_pos_t        dst_addr,
    output logic             last
);

    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             col_end;

    assign col_end = (col == width_m1);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            row <= '0;
            col <= '0;
        end else if (load) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (col_end) begin
                col <= '0;
                row <= row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    assign last     = col_end && (row == height_m1);
    assign src_addr = wrap_add(src, row, col);
    assign dst_addr = wrap_add(dst, row, col);

endmodule

// File: rtl/map_blitter.sv
// map_blitter
// Tile-map blitter: fills a rectangular block of the tile map with a constant
// tile index, or copies a block from SRC to DST, through the CPU-side port of
// the map RAM, yielding to the CPU whenever cpu_map_busy is high.
//   clock, reset_n : clock, synchronous active-low reset
//   bus (slave)    : CPU register bus, map RAM strobes, done pulse
//   state_dbg      : current FSM state for observation
// Registers (address[4:2]): 0 SRC, 1 DST, 2 SIZE, 3 FILL, 4 CTRL(w)/STATUS(r).
module map_blitter
    import map_blitter_pkg::*;
(
    input  logic          clock,
    input  logic          reset_n,
    map_blitter_if.slave  bus,
    output state_t        state_dbg
);

    state_t            state, state_next;
    tile_pos_t         src, dst, src_addr, dst_addr;
    logic [COL_W-1:0]  width_m1;
    logic [ROW_W-1:0]  height_m1;
    logic [TILE_W-1:0] fill, hold;
    logic              mode;
    logic [31:0]       data_out_q, read_mux;
    logic              done_q, done_next;
    logic              cnt_load, cnt_advance, last_tile;
    logic              busy;
    logic              reg_wr, reg_rd, ctrl_wr, start_req, abort_req;
    logic              map_cs_c, map_read_c, map_write_c;
    logic [ADDR_W-1:0] map_addr_c;
    logic [TILE_W-1:0] map_wdata_c;
    logic              unused_data_in;

    assign unused_data_in = ^bus.data_in[31:13];

    // ---------------- CPU register decode ----------------
    assign busy      = (state != IDLE);
    assign reg_wr    = bus.blit_cs && bus.write;
    assign reg_rd    = bus.blit_cs && bus.read;
    assign ctrl_wr   = reg_wr && (bus.address == REG_CTRL);
    assign abort_req = ctrl_wr && bus.data_in[CTRL_ABORT];
    // Abort in the same write cancels the start.
    assign start_req = ctrl_wr && bus.data_in[CTRL_START] && !abort_req;

    // Configuration is frozen while an operation is running.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            src       <= '0;
            dst       <= '0;
            width_m1  <= '0;
            height_m1 <= '0;
            fill      <= '0;
        end else if (reg_wr && !busy) begin
            case (bus.address)
                REG_SRC:  src  <= bus.data_in[11:2];
                REG_DST:  dst  <= bus.data_in[11:2];
                REG_SIZE: begin
                    width_m1  <= bus.data_in[4:0];
                    height_m1 <= bus.data_in[12:8];
                end
                REG_FILL: fill <= bus.data_in[7:0];
                default:  ;
            endcase
        end
    end

    // Mode is captured only by an accepted start.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            mode <= 1'b0;
        end else if (start_req && !busy) begin
            mode <= bus.data_in[CTRL_MODE];
        end
    end

    always_comb begin
        read_mux = '0;
        case (bus.address)
            REG_SRC:  read_mux[11:2] = src;
            REG_DST:  read_mux[11:2] = dst;
            REG_SIZE: begin
                read_mux[4:0]  = width_m1;
                read_mux[12:8] = height_m1;
            end
            REG_FILL: read_mux[7:0] = fill;
            REG_CTRL: begin
                read_mux[STAT_BUSY] = busy;
                read_mux[STAT_MODE] = mode;
            end
            default:  ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            data_out_q <= '0;
        end else if (reg_rd) begin
            data_out_q <= read_mux;
        end
    end

    // ---------------- traversal counters ----------------
    map_blit_addr_gen u_addr_gen (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (cnt_load),
        .advance   (cnt_advance),
        .width_m1  (width_m1),
        .height_m1 (height_m1),
        .src       (src),
        .dst       (dst),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .last      (last_tile)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Strobes are combinational from the state so a stall or an abort seen on
    // the bus this cycle suppresses them in the very same cycle.
    always_comb begin
        state_next  = state;
        cnt_load    = 1'b0;
        cnt_advance = 1'b0;
        done_next   = 1'b0;
        map_cs_c    = 1'b0;
        map_read_c  = 1'b0;
        map_write_c = 1'b0;
        map_addr_c  = '0;
        map_wdata_c = '0;
        if (abort_req) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_req) begin
                        cnt_load   = 1'b1;
                        state_next = bus.data_in[CTRL_MODE] ? RD : WR;
                    end
                end
                RD: begin
                    if (!bus.cpu_map_busy) begin
                        map_cs_c   = 1'b1;
                        map_read_c = 1'b1;
                        map_addr_c = src_addr;
                        state_next = LATCH;
                    end
                end
                LATCH: begin
                    state_next = WR;
                end
                WR: begin
                    if (!bus.cpu_map_busy) begin
                        map_cs_c    = 1'b1;
                        map_write_c = 1'b1;
                        map_addr_c  = dst_addr;
                        map_wdata_c = mode ? hold : fill;
                        cnt_advance = 1'b1;
                        if (last_tile) begin
                            state_next = IDLE;
                            done_next  = 1'b1;
                        end else begin
                            state_next = mode ? RD : WR;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Read data returns the cycle after RD, which is exactly the LATCH cycle.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            hold <= '0;
        end else if (state == LATCH) begin
            hold <= bus.map_rdata;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_next;
        end
    end

    assign bus.map_cs      = map_cs_c;
    assign bus.map_read    = map_read_c;
    assign bus.map_write   = map_write_c;
    assign bus.map_address = map_addr_c;
    assign bus.map_wdata   = map_wdata_c;
    assign bus.data_out    = data_out_q;
    assign bus.done        = done_q;
    assign state_dbg       = state;

endmodule
